// File: rtl/toy_cov_pkg.sv
// Shared constants, FSM encoding and bitmap indexing for the toy processor
// state-coverage monitor.
package toy_cov_pkg;

    localparam int NUM_STATES = 8;
    localparam int SINK_STATE = 7;
    localparam int STATE_W    = 5;
    localparam int COV_CNT_W  = 7;

    localparam logic [STATE_W-1:0] S0 = 5'd0;
    localparam logic [STATE_W-1:0] S1 = 5'd1;
    localparam logic [STATE_W-1:0] S2 = 5'd2;
    localparam logic [STATE_W-1:0] S3 = 5'd3;
    localparam logic [STATE_W-1:0] S4 = 5'd4;
    localparam logic [STATE_W-1:0] S5 = 5'd5;
    localparam logic [STATE_W-1:0] S6 = 5'd6;
    localparam logic [STATE_W-1:0] S7 = 5'd7;

    typedef enum logic {
        TRACK = 1'b0,
        DONE  = 1'b1
    } fsm_e;

    // Bitmap position of the from->to transition; row-major by source state.
    function automatic int trans_idx(input int from, input int to, input int num);
        return from * num + to;
    endfunction

endpackage

// File: rtl/toy_sat_counter.sv
// Saturating up-counter with synchronous clear; one instance per tracked state.
module toy_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/toy_state_cov_monitor.sv
// Samples the upstream FSM state each clock and builds transition coverage,
// per-state visit counts, a new-coverage pulse and an end-of-episode flag.
module toy_state_cov_monitor #(
    parameter int NUM_STATES  = toy_cov_pkg::NUM_STATES,
    parameter int SINK_STATE  = toy_cov_pkg::SINK_STATE,
    parameter int SINK_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [toy_cov_pkg::STATE_W-1:0]      state,
    input  logic                                 clear_episode,
    input  logic                                 clear_all,
    input  logic                                 rd_req,
    input  logic [$clog2(NUM_STATES)-1:0]        rd_idx,
    output logic                                 rd_valid,
    output logic [CNT_W-1:0]                     rd_data,
    output logic [NUM_STATES*NUM_STATES-1:0]     cov_map,
    output logic [toy_cov_pkg::COV_CNT_W-1:0]    cov_count,
    output logic                                 new_cov,
    output logic                                 oor_flag,
    output logic                                 episode_done
);

    localparam int IDX_W   = $clog2(NUM_STATES);
    localparam int MAP_W   = NUM_STATES * NUM_STATES;
    localparam int MAP_IW  = $clog2(MAP_W);
    localparam int SINK_CW = $clog2(SINK_CYCLES + 1);
    localparam int STATE_W = toy_cov_pkg::STATE_W;
    localparam int COV_W   = toy_cov_pkg::COV_CNT_W;

    toy_cov_pkg::fsm_e    fsm_q, fsm_d;
    logic [STATE_W-1:0]   prev_state_q, prev_state_d;
    logic                 prev_valid_q, prev_valid_d;
    logic [SINK_CW-1:0]   sink_cnt_q, sink_cnt_d;
    logic [MAP_W-1:0]     cov_map_q, cov_map_d;
    logic [COV_W-1:0]     cov_count_q, cov_count_d;
    logic                 new_cov_q, new_cov_d;
    logic                 oor_flag_q, oor_flag_d;
    logic                 episode_done_q, episode_done_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0]     rd_data_q, rd_data_d;

    logic [NUM_STATES-1:0] visit_inc;
    logic [CNT_W-1:0]      visit [NUM_STATES];
    logic                  sample_ok;
    logic                  prev_ok;
    logic [MAP_IW-1:0]     bit_idx;

    assign sample_ok = int'(state) < NUM_STATES;
    assign prev_ok   = int'(prev_state_q) < NUM_STATES;
    assign bit_idx   = MAP_IW'(toy_cov_pkg::trans_idx(int'(prev_state_q), int'(state), NUM_STATES));

    // NOTE: the visit counters are reset flops rather than a RAM, so an async reset
    // mid-episode leaves no stale counts behind.
    for (genvar i = 0; i < NUM_STATES; i++) begin : g_visit
        toy_sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (visit_inc[i]),
            .clr   (clear_all),
            .cnt   (visit[i])
        );
    end

    // NOTE: every signal written here gets a default first, so no path leaves a latch.
    always_comb begin
        fsm_d          = fsm_q;
        prev_state_d   = prev_state_q;
        prev_valid_d   = prev_valid_q;
        sink_cnt_d     = sink_cnt_q;
        cov_map_d      = cov_map_q;
        cov_count_d    = cov_count_q;
        new_cov_d      = 1'b0;
        oor_flag_d     = oor_flag_q;
        episode_done_d = episode_done_q;
        visit_inc      = '0;
        rd_valid_d     = rd_req;
        rd_data_d      = '0;

        // Reads see the registered counts, i.e. the value before any same-cycle increment.
        if (int'(rd_idx) < NUM_STATES) begin
            rd_data_d = visit[rd_idx];
        end

        if (clear_all || clear_episode) begin
            fsm_d          = toy_cov_pkg::TRACK;
            prev_valid_d   = 1'b0;
            sink_cnt_d     = '0;
            episode_done_d = 1'b0;
            if (clear_all) begin
                cov_map_d   = '0;
                cov_count_d = '0;
                oor_flag_d  = 1'b0;
            end
        end else if (fsm_q == toy_cov_pkg::TRACK) begin
            prev_state_d = state;
            prev_valid_d = 1'b1;
            if (sample_ok) begin
                visit_inc[state[IDX_W-1:0]] = 1'b1;
                if (prev_valid_q && prev_ok && !cov_map_q[bit_idx]) begin
                    cov_map_d[bit_idx] = 1'b1;
                    cov_count_d        = cov_count_q + COV_W'(1);
                    new_cov_d          = 1'b1;
                end
            end else begin
                oor_flag_d = 1'b1;
            end

            if (state == STATE_W'(SINK_STATE)) begin
                if (sink_cnt_q != SINK_CW'(SINK_CYCLES)) begin
                    sink_cnt_d = sink_cnt_q + SINK_CW'(1);
                end
            end else begin
                sink_cnt_d = '0;
            end

            if (sink_cnt_d == SINK_CW'(SINK_CYCLES)) begin
                fsm_d          = toy_cov_pkg::DONE;
                episode_done_d = 1'b1;
            end
        end
    end

    // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q          <= toy_cov_pkg::TRACK;
            prev_state_q   <= '0;
            prev_valid_q   <= 1'b0;
            sink_cnt_q     <= '0;
            cov_map_q      <= '0;
            cov_count_q    <= '0;
            new_cov_q      <= 1'b0;
            oor_flag_q     <= 1'b0;
            episode_done_q <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
        end else begin
            fsm_q          <= fsm_d;
            prev_state_q   <= prev_state_d;
            prev_valid_q   <= prev_valid_d;
            sink_cnt_q     <= sink_cnt_d;
            cov_map_q      <= cov_map_d;
            cov_count_q    <= cov_count_d;
            new_cov_q      <= new_cov_d;
            oor_flag_q     <= oor_flag_d;
            episode_done_q <= episode_done_d;
            rd_valid_q     <= rd_valid_d;
            rd_data_q      <= rd_data_d;
        end
    end

    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign cov_map      = cov_map_q;
    assign cov_count    = cov_count_q;
    assign new_cov      = new_cov_q;
    assign oor_flag     = oor_flag_q;
    assign episode_done = episode_done_q;

endmodule

// File: tb/tb_toy_state_cov_monitor.sv
// Directed bench for toy_state_cov_monitor: a behavioural coverage model checked
// every cycle, plus literal expectations at the end of each scenario.
module tb_toy_state_cov_monitor;
    import toy_cov_pkg::*;

    localparam int NS    = 8;
    localparam int SINK  = 7;
    localparam int SINKC = 4;
    localparam int CMAX  = 255;

    logic        clk           = 1'b0;
    logic        reset         = 1'b1;
    logic [4:0]  state         = 5'd0;
    logic        clear_episode = 1'b0;
    logic        clear_all     = 1'b0;
    logic        rd_req        = 1'b0;
    logic [2:0]  rd_idx        = 3'd0;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic [63:0] cov_map;
    logic [6:0]  cov_count;
    logic        new_cov;
    logic        oor_flag;
    logic        episode_done;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;

    // Model state: plain integers and a bit set.
    int        m_visit [NS];
    bit [63:0] m_map        = '0;
    int        m_prev       = 0;
    bit        m_prev_valid = 1'b0;
    int        m_sink       = 0;
    bit        m_done       = 1'b0;
    bit        m_oor        = 1'b0;
    bit        exp_new      = 1'b0;
    bit        exp_rd_valid = 1'b0;
    int        exp_rd_data  = 0;

    toy_state_cov_monitor #(
        .NUM_STATES  (8),
        .SINK_STATE  (7),
        .SINK_CYCLES (4),
        .CNT_W       (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .state         (state),
        .clear_episode (clear_episode),
        .clear_all     (clear_all),
        .rd_req        (rd_req),
        .rd_idx        (rd_idx),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .cov_map       (cov_map),
        .cov_count     (cov_count),
        .new_cov       (new_cov),
        .oor_flag      (oor_flag),
        .episode_done  (episode_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_wipe_all();
        for (int i = 0; i < NS; i++) m_visit[i] = 0;
        m_map = '0;
        m_oor = 1'b0;
    endtask

    task automatic model_step();
        int idx;
        if (reset) begin
            model_wipe_all();
            m_prev       = 0;
            m_prev_valid = 1'b0;
            m_sink       = 0;
            m_done       = 1'b0;
            exp_new      = 1'b0;
            exp_rd_valid = 1'b0;
            exp_rd_data  = 0;
        end else begin
            exp_rd_valid = rd_req;
            exp_rd_data  = (int'(rd_idx) < NS) ? m_visit[rd_idx] : 0;
            exp_new      = 1'b0;
            if (clear_all || clear_episode) begin
                if (clear_all) model_wipe_all();
                m_prev_valid = 1'b0;
                m_sink       = 0;
                m_done       = 1'b0;
            end else if (!m_done) begin
                if (int'(state) < NS) begin
                    if (m_visit[state] < CMAX) m_visit[state]++;
                    if (m_prev_valid && m_prev < NS) begin
                        idx = m_prev * NS + int'(state);
                        if (!m_map[idx]) begin
                            m_map[idx] = 1'b1;
                            exp_new    = 1'b1;
                        end
                    end
                end else begin
                    m_oor = 1'b1;
                end
                m_prev       = int'(state);
                m_prev_valid = 1'b1;
                if (int'(state) == SINK) m_sink = (m_sink < SINKC) ? m_sink + 1 : m_sink;
                else                     m_sink = 0;
                if (m_sink == SINKC) m_done = 1'b1;
            end
        end
    endtask

    always @(posedge clk or posedge reset) model_step();

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            check("rd_valid", rd_valid, exp_rd_valid);
            if (exp_rd_valid) check("rd_data", rd_data, exp_rd_data);
            check("cov_map", cov_map, m_map);
            check("cov_count", cov_count, $countones(m_map));
            check("new_cov", new_cov, exp_new);
            check("oor_flag", oor_flag, m_oor);
            check("episode_done", episode_done, m_done);
            if (new_cov) pulses++;
        end
    end

    task automatic step(input logic [4:0] s);
        state = s;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset cov_map", cov_map, 64'd0);
        check("reset cov_count", cov_count, 64'd0);
        check("reset episode_done", episode_done, 64'd0);
        check("reset rd_valid", rd_valid, 64'd0);

        // Test 1: 0,1,7,7,7,7 reaches the sink.
        step(S0); step(S1); step(S7); step(S7); step(S7);
        check("t1 not yet done", episode_done, 64'd0);
        step(S7);
        check("t1 episode_done", episode_done, 64'd1);
        check("t1 cov_map", cov_map, 64'h8000_0000_0000_8002);
        check("t1 cov_count", cov_count, 64'd3);
        check("t1 pulses", pulses, 64'd3);

        // Test 6: reads in DONE, visits frozen.
        rd_req = 1'b1; rd_idx = 3'd7; step(S7);
        check("t6 rd_valid", rd_valid, 64'd1);
        check("t6 rd_data v7", rd_data, 64'd4);
        rd_idx = 3'd5; step(S7);
        check("t6 rd_data v5", rd_data, 64'd0);
        rd_idx = 3'd7; step(S7);
        check("t6 rd_data v7 frozen", rd_data, 64'd4);
        rd_req = 1'b0; step(S7);
        check("t6 rd_valid low", rd_valid, 64'd0);

        // Test 2: clear_episode drops its own sample, bitmap kept.
        clear_episode = 1'b1; step(S3); clear_episode = 1'b0;
        check("t2 done cleared", episode_done, 64'd0);
        step(S0); step(S1); step(S2); step(S7);
        check("t2 cov_map", cov_map, 64'h8000_0000_0080_8402);
        check("t2 cov_count", cov_count, 64'd5);
        check("t2 pulses", pulses, 64'd5);
        rd_req = 1'b1; rd_idx = 3'd1; step(S7); rd_req = 1'b0;
        check("t2 rd_data v1", rd_data, 64'd2);

        // Test 3: out-of-range sample.
        step(S3); step(5'd9); step(S4);
        check("t3 oor_flag", oor_flag, 64'd1);
        check("t3 cov_map", cov_map, 64'h8800_0000_0080_8402);
        check("t3 cov_count", cov_count, 64'd6);

        // Test 4: saturation of visit[3].
        for (int i = 0; i < 300; i++) step(S3);
        check("t4 cov_map", cov_map, 64'h8800_0008_0880_8402);
        check("t4 cov_count", cov_count, 64'd8);
        check("t4 pulses", pulses, 64'd8);
        rd_req = 1'b1; rd_idx = 3'd3; step(S3); rd_req = 1'b0;
        check("t4 rd_data v3 sat", rd_data, 64'd255);

        // Test 5: both clears with a read; clear_all wins, read sees pre-clear value.
        clear_all = 1'b1; clear_episode = 1'b1; rd_req = 1'b1; rd_idx = 3'd3;
        step(S1);
        clear_all = 1'b0; clear_episode = 1'b0; rd_req = 1'b0;
        check("t5 rd_data pre-clear", rd_data, 64'd255);
        check("t5 cov_map", cov_map, 64'd0);
        check("t5 cov_count", cov_count, 64'd0);
        check("t5 new_cov", new_cov, 64'd0);
        check("t5 oor_flag", oor_flag, 64'd0);
        rd_req = 1'b1;
        for (int i = 0; i < NS; i++) begin
            rd_idx = 3'(i);
            step(S0);
            check("t5 visit cleared", rd_data, 64'd0);
        end
        rd_req = 1'b0;
        step(S2); step(S7);
        check("t5 tracking again", cov_map, 64'h0000_0000_0080_0005);
        check("t5 cov_count again", cov_count, 64'd3);

        // Async reset mid-episode.
        step(S7); step(S7);
        #2 reset = 1'b1;
        #1;
        check("areset cov_map", cov_map, 64'd0);
        check("areset cov_count", cov_count, 64'd0);
        check("areset episode_done", episode_done, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        step(S7); step(S7);
        rd_req = 1'b1; rd_idx = 3'd7; step(S7); rd_req = 1'b0;
        check("areset rd_data v7", rd_data, 64'd2);
        check("areset not done", episode_done, 64'd0);
        check("areset cov_map", cov_map, 64'h8000_0000_0000_0000);
        step(S7);
        check("areset done after 4", episode_done, 64'd1);

        step(S7);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
